// File: rtl/skolem_urem_checker.sv
// ---------------------------------------------------------------------------
// skolem_urem_checker
//
// Checks, one triple at a time, that a witness x produced by an upstream
// Skolem stage satisfies  x urem s == t  (SMT-LIB semantics: x urem 0 == x).
// The remainder is computed by a 4-step restoring division, MSB of x first.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. The producer holds valid and data stable until that edge; valid
// never depends on ready. This applies to in_valid/in_ready and to
// out_valid/out_ready.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   candidate triple (s, t, x) presented
//   in_ready   block can accept a triple this cycle (IDLE only)
//   s          divisor operand, 4 bits
//   t          target remainder, 4 bits
//   x          witness, 4 bits
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   rem        registered x urem s
//   pass       registered (rem == t)
//   pass_cnt   saturating count of passing results (0 unless stats enabled)
//   fail_cnt   saturating count of failing results (0 unless stats enabled)
//   dbg_state  current FSM state (0 IDLE, 1 DIV, 2 DONE)
//
// Configuration macro: SKOLEM_CHK_STATS_EN -- when defined, pass_cnt and
// fail_cnt count completed output handshakes; otherwise both are tied to 0.
// ---------------------------------------------------------------------------
module skolem_urem_checker (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] s,
   input  logic [3:0] t,
   input  logic [3:0] x,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] rem,
   output logic       pass,
   output logic [7:0] pass_cnt,
   output logic [7:0] fail_cnt,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state_q;
   state_t     state_d;

   logic [3:0] s_q;
   logic [3:0] t_q;
   logic [3:0] x_q;
   logic [3:0] r_q;
   logic [1:0] cnt_q;
   logic [3:0] rem_q;
   logic       pass_q;
   logic       vld_q;

   logic       accept;
   logic       hs;
   logic [4:0] r_sh;
   logic       ge;
   logic [3:0] r_sub;
   logic [3:0] r_nx;

   assign accept = (state_q == IDLE) && in_valid;
   // vld_q can only be set while in DONE, so this is the output handshake.
   assign hs     = vld_q && out_ready;

   // One restoring-division step. The partial remainder stays below s, so
   // r_sh < 2*s and any difference taken fits in 4 bits; a 4-bit modular
   // subtraction of the low bits therefore gives the exact result. With
   // s == 0 the compare always succeeds and subtracting 0 just shifts x in.
   always_comb begin
      r_sh  = {r_q, x_q[cnt_q]};
      ge    = (r_sh >= {1'b0, s_q});
      r_sub = r_sh[3:0] - s_q;
      r_nx  = ge ? r_sub : r_sh[3:0];
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)       state_d = DIV;
         DIV:     if (cnt_q == 2'd0)  state_d = DONE;
         DONE:    if (hs)             state_d = IDLE;
         default:                     state_d = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = vld_q;
      rem       = rem_q;
      pass      = pass_q;
      dbg_state = state_q;
   end

   // Datapath. The result registers are loaded on the last DIV step and
   // out_valid follows one edge later, giving a five-edge latency from the
   // accepting edge to out_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q    <= '0;
         t_q    <= '0;
         x_q    <= '0;
         r_q    <= '0;
         cnt_q  <= '0;
         rem_q  <= '0;
         pass_q <= 1'b0;
         vld_q  <= 1'b0;
      end else begin
         if (accept) begin
            s_q   <= s;
            t_q   <= t;
            x_q   <= x;
            r_q   <= '0;
            cnt_q <= 2'd3;
         end else if (state_q == DIV) begin
            r_q   <= r_nx;
            cnt_q <= cnt_q - 2'd1;
            if (cnt_q == 2'd0) begin
               rem_q  <= r_nx;
               pass_q <= (r_nx == t_q);
            end
         end
         vld_q <= (state_q == DONE) && !hs;
      end
   end

`ifdef SKOLEM_CHK_STATS_EN
   logic [7:0] pass_cnt_q;
   logic [7:0] fail_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pass_cnt_q <= '0;
         fail_cnt_q <= '0;
      end else if (hs) begin
         if (pass_q) begin
            if (pass_cnt_q != 8'hFF) pass_cnt_q <= pass_cnt_q + 8'd1;
         end else begin
            if (fail_cnt_q != 8'hFF) fail_cnt_q <= fail_cnt_q + 8'd1;
         end
      end
   end

   assign pass_cnt = pass_cnt_q;
   assign fail_cnt = fail_cnt_q;
`else
   assign pass_cnt = 8'd0;
   assign fail_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_skolem_urem_checker.sv
// ---------------------------------------------------------------------------
// Testbench for skolem_urem_checker. Compile with +define+SKOLEM_CHK_STATS_EN
// to exercise the result counters; expectations follow the macro.
// ---------------------------------------------------------------------------
module tb_skolem_urem_checker;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] s;
   logic [3:0] t;
   logic [3:0] x;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] rem;
   logic       pass;
   logic [7:0] pass_cnt;
   logic [7:0] fail_cnt;
   logic [1:0] dbg_state;

   skolem_urem_checker dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .s         (s),
      .t         (t),
      .x         (x),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .rem       (rem),
      .pass      (pass),
      .pass_cnt  (pass_cnt),
      .fail_cnt  (fail_cnt),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   logic [4:0] exp_q[$];     // {rem, pass}
   int         n_checks = 0;
   int         n_fail   = 0;
   int         m_pass   = 0; // model of pass_cnt (stats enabled)
   int         m_fail   = 0; // model of fail_cnt (stats enabled)

   typedef struct {
      logic [3:0] s;
      logic [3:0] t;
      logic [3:0] x;
      logic [3:0] rem;
      logic       pass;
      int         hold;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input int act, input int exp_v);
      n_checks++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
      end
   endtask

   function automatic logic [3:0] model_rem(input logic [3:0] ss, input logic [3:0] xx);
      if (ss == 4'd0) return xx;
      return xx % ss;
   endfunction

   function automatic int exp_cnt(input int v);
`ifdef SKOLEM_CHK_STATS_EN
      return (v > 255) ? 255 : v;
`else
      return 0 * v;
`endif
   endfunction

   // ---------------- driver ----------------
   // Presents one triple at a negedge, pushes the expected result, measures
   // latency, optionally holds out_ready low for 'hold' cycles, then
   // completes the output handshake.
   task automatic run_triple(input logic [3:0] ss, input logic [3:0] tt,
                             input logic [3:0] xx, input logic [3:0] er,
                             input logic ep, input int hold, input string tag);
      int         lat;
      int         n;
      logic [4:0] e;
      logic [3:0] r0;
      logic       p0;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_ready"}, in_ready, 1);
      s = ss; t = tt; x = xx; in_valid = 1'b1;
      exp_q.push_back({er, ep});
      @(posedge clk);                      // accepting edge
      @(negedge clk);
      in_valid = 1'b0;
      s = 4'($urandom_range(0, 15));       // operands must already be captured
      t = 4'($urandom_range(0, 15));
      x = 4'($urandom_range(0, 15));
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check({tag, "_latency"}, lat, 5);
      e = exp_q.pop_front();
      check({tag, "_rem"}, rem, e[4:1]);
      check({tag, "_pass"}, pass, e[0]);
      if (hold > 0) begin
         r0 = rem;
         p0 = pass;
         for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_rem"}, rem, r0);
            check({tag, "_hold_pass"}, pass, p0);
            check({tag, "_hold_in_ready"}, in_ready, 0);
         end
         in_valid = 1'b0;
      end
      out_ready = 1'b1;
      @(posedge clk);                      // output handshake
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_valid_fall"}, out_valid, 0);
      check({tag, "_idle_ready"}, in_ready, 1);
      if (e[0]) m_pass++;
      else m_fail++;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int viol;
      logic [3:0] r_e;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      s = '0; t = '0; x = '0;

      vecs[0] = '{4'd5,  4'd3,  4'd13, 4'd3,  1'b1, 0};
      vecs[1] = '{4'd0,  4'd7,  4'd7,  4'd7,  1'b1, 0};
      vecs[2] = '{4'd0,  4'd0,  4'd7,  4'd7,  1'b0, 0};
      vecs[3] = '{4'd3,  4'd2,  4'd4,  4'd1,  1'b0, 10};
      vecs[4] = '{4'd15, 4'd0,  4'd15, 4'd0,  1'b1, 0};
      vecs[5] = '{4'd7,  4'd6,  4'd15, 4'd1,  1'b0, 0};
      vecs[6] = '{4'd1,  4'd0,  4'd15, 4'd0,  1'b1, 0};
      vecs[7] = '{4'd15, 4'd14, 4'd14, 4'd14, 1'b1, 0};
      vecs[8] = '{4'd9,  4'd5,  4'd0,  4'd0,  1'b0, 2};

      repeat (3) @(negedge clk);
      check("rst_in_ready_low", in_ready, 1);
      rst_n = 1'b1;
      check("rst_out_valid", out_valid, 0);
      check("rst_rem", rem, 0);
      check("rst_pass", pass, 0);
      check("rst_pass_cnt", pass_cnt, 0);
      check("rst_fail_cnt", fail_cnt, 0);
      check("rst_in_ready", in_ready, 1);

      // Table vectors; the first is presented right after reset release.
      for (int i = 0; i < 9; i++)
         run_triple(vecs[i].s, vecs[i].t, vecs[i].x, vecs[i].rem, vecs[i].pass,
                    vecs[i].hold, $sformatf("vec%0d", i));
      check("tbl_pass_cnt", pass_cnt, exp_cnt(m_pass));
      check("tbl_fail_cnt", fail_cnt, exp_cnt(m_fail));

      // Reset during the second DIV cycle discards the triple.
      @(negedge clk);
      s = 4'd3; t = 4'd1; x = 4'd10; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_state", dbg_state, 0);
      check("mid_rst_out_valid", out_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      m_pass = 0;
      m_fail = 0;
      check("mid_rst_in_ready", in_ready, 1);
      viol = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (out_valid) viol++;
      end
      check("mid_rst_no_output", viol, 0);
      check("mid_rst_pass_cnt", pass_cnt, 0);
      check("mid_rst_fail_cnt", fail_cnt, 0);
      check("mid_rst_rem", rem, 0);

      // 300 passing triples: pass counter saturates.
      for (int i = 0; i < 300; i++)
         run_triple(4'd1, 4'd0, 4'd9, 4'd0, 1'b1, 0, "sat");
      check("sat_pass_cnt", pass_cnt, exp_cnt(300));
      check("sat_fail_cnt", fail_cnt, 0);

      // Exhaustive sweep, expectations from the reference model.
      for (int i = 0; i < 4096; i++) begin
         logic [11:0] v;
         v = 12'(i);
         r_e = model_rem(v[3:0], v[11:8]);
         run_triple(v[3:0], v[7:4], v[11:8], r_e, (r_e == v[7:4]), 0, "sweep");
      end
      check("sweep_pass_cnt", pass_cnt, exp_cnt(m_pass));
      check("sweep_fail_cnt", fail_cnt, exp_cnt(m_fail));
      check("scoreboard_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/skolem_urem_checker.md
SKOLEM_UREM_CHECKER -- requirements
Module: skolem_urem_checker

Interface
REQ-001 Clocking and reset: one clock, clk; asynchronous, active-low reset, rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  a candidate triple (s, t, x) is presented.
REQ-005 in_ready  output  1  block can accept a triple this cycle.
REQ-006 s  input  4  divisor operand (Skolem inputs i0..i3, bit i0 = LSB).
REQ-007 t  input  4  target remainder (Skolem inputs i4..i7, bit i4 = LSB).
REQ-008 x  input  4  witness produced by the Skolem function (i8..i11, bit i8 = LSB).
REQ-009 out_valid  output  1  result is valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 rem  output  4  computed x urem s.
REQ-012 pass  output  1  1 when rem == t.
REQ-013 pass_cnt, fail_cnt  output  8 each  saturating result counters (REQ-032).

Function
REQ-014 Purpose: sequentially check the constraint x urem s == t for each witness emitted by the upstream Skolem stage.
REQ-015 FSM states: IDLE, DIV, DONE.
REQ-016 IDLE: in_ready=1; in_valid=1 on a rising edge registers s, t and x, clears the partial remainder, loads the iteration counter with 3, and moves to DIV.
REQ-017 DIV: in_ready=0; restoring division, one quotient bit per cycle, MSB of x first.
- r' = {r[3:0], x_bit} in 5 bits.
- If r' >= {0, s}, then r = r' - s; otherwise r = r'.
REQ-018 DIV runs for exactly 4 cycles, counter 3 down to 0; after the counter-0 iteration the FSM moves to DONE.
REQ-019 SMT-LIB semantics: s == 0 yields rem = x with no special path, and the latency is unchanged.
REQ-020 DONE: out_valid=1; rem holds the final remainder; pass = (rem == t); in_ready=0.
REQ-021 Latency: out_valid rises on the 5th rising edge after the accepting edge, regardless of the operands.
REQ-022 DONE with out_ready=1 completes the output handshake on that edge: FSM returns to IDLE and out_valid falls.
REQ-023 DONE with out_ready=0: FSM holds DONE, and rem and pass stay stable.
REQ-024 Throughput: at most one triple per 6 cycles. No input is accepted in the cycle the output handshake completes, because in_ready rises one cycle later.
REQ-025 in_valid while in_ready=0 is ignored; the upstream stage holds its data.
REQ-026 rem and pass are registered outputs that hold the last result until the next DONE.

Reset
REQ-027 rst_n low immediately forces IDLE, independent of clk.
REQ-028 Reset values: in_ready=1 after release, out_valid=0, rem=0, pass=0, pass_cnt=0, fail_cnt=0, internal registers 0.
REQ-029 Reset asserted mid-DIV or mid-DONE discards the in-flight triple; no result and no count update are produced.
REQ-030 The first acceptance is possible on the first rising edge after rst_n deasserts.

Configuration
REQ-031 Macro SKOLEM_CHK_STATS_EN controls the result counters.
REQ-032 With SKOLEM_CHK_STATS_EN defined:
- Each completed output handshake increments pass_cnt if pass=1, otherwise fail_cnt.
- Both counters saturate at 255.
REQ-033 Without SKOLEM_CHK_STATS_EN: pass_cnt and fail_cnt are tied to 0, no counter flops exist, and all other behaviour is identical.

Verification
REQ-034 s=5, t=3, x=13 -> out_valid 5 cycles after acceptance, rem=3, pass=1.
REQ-035 s=0, t=7, x=7 -> rem=7, pass=1, latency 5; then s=0, t=0, x=7 -> pass=0.
REQ-036 s=3, t=2, x=4 with out_ready=0 held for 10 cycles -> rem=1 and pass=0 stable throughout, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-037 rst_n pulsed low on the 2nd DIV cycle -> out_valid never rises for that triple, counters unchanged, in_ready=1 after release.
REQ-038 STATS_EN defined, 300 passing triples (s=1, t=0, x=9) -> pass_cnt=255, fail_cnt=0; macro undefined -> both read 0.
REQ-039 Exhaustive sweep over all 4096 (s, t, x) combinations -> rem always equals x mod s (rem equals x when s=0).
